// File: rtl/wb_stream_reader_cfg_if.sv
// Wishbone B3 classic slave bus bundle for the stream reader config block.
// Latency: none (wires only).
// Backpressure: none here; the slave terminates each request with ack or err.
interface wb_stream_reader_cfg_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  logic [WB_AW-1:0]   wbs_adr_i;
  logic [WB_DW-1:0]   wbs_dat_i;
  logic [WB_DW/8-1:0] wbs_sel_i;
  logic               wbs_we_i;
  logic               wbs_cyc_i;
  logic               wbs_stb_i;
  logic [2:0]         wbs_cti_i;
  logic [1:0]         wbs_bte_i;
  logic [WB_DW-1:0]   wbs_dat_o;
  logic               wbs_ack_o;
  logic               wbs_err_o;
  logic               wbs_rty_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
           wbs_cti_i, wbs_bte_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
           wbs_cti_i, wbs_bte_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/wb_stream_reader_cfg.sv
// Wishbone register block configuring/monitoring the stream reader DMA core.
// Latency: one wait state; ack/err and read data registered the cycle after the request.
// Backpressure: back-to-back requests terminate every other cycle; rty is never used.
module wb_stream_reader_cfg #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_stream_reader_cfg_if.slave wb,
  input  logic                 word_done,
  input  logic                 busy,
  output logic                 enable,
  output logic [WB_AW-1:0]     start_adr,
  output logic [WB_AW-1:0]     buf_size,
  output logic [WB_AW-1:0]     burst_size,
  output logic                 irq
);

  localparam int SW = WB_DW / 8;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_STATUS = 3'd1,
    REG_START  = 3'd2,
    REG_BUF    = 3'd3,
    REG_BURST  = 3'd4,
    REG_CNT    = 3'd5
  } reg_e;

  logic             irq_en;
  logic             irq_pend;
  logic [WB_AW-1:0] word_cnt;

  logic             req;
  logic [2:0]       off;
  logic             mapped;
  logic             wr;
  logic             rd;
  logic [WB_DW-1:0] rdata;
  logic [WB_AW:0]   cnt_inc;
  logic             cnt_step;
  logic             wrap;
  logic             en_rise;
  logic             pend_clr;
  logic             unused_ok;

  // Byte-lane merge of write data into the current register value.
  function automatic logic [WB_DW-1:0] merge(input logic [WB_DW-1:0] old,
                                             input logic [WB_DW-1:0] din,
                                             input logic [SW-1:0]    sel);
    logic [WB_DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++) begin
      if (sel[i]) r[8*i +: 8] = din[8*i +: 8];
    end
    return r;
  endfunction

  // A new request is only accepted while no termination is already showing.
  assign req    = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o & ~wb.wbs_err_o;
  assign off    = wb.wbs_adr_i[4:2];
  assign mapped = (off <= 3'd5);
  assign wr     = req & wb.wbs_we_i & mapped;
  assign rd     = req & ~wb.wbs_we_i & mapped;

  assign wb.wbs_rty_o = 1'b0;

  // cti/bte are ignored (classic only) and only address bits [4:2] decode.
  assign unused_ok = ^{wb.wbs_cti_i, wb.wbs_bte_i,
                       wb.wbs_adr_i[WB_AW-1:5], wb.wbs_adr_i[1:0]};

  // Read mux for the six mapped registers.
  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:   rdata = WB_DW'({irq_en, enable});
      REG_STATUS: rdata = WB_DW'({irq_pend, busy});
      REG_START:  rdata = WB_DW'(start_adr);
      REG_BUF:    rdata = WB_DW'(buf_size);
      REG_BURST:  rdata = WB_DW'(burst_size);
      REG_CNT:    rdata = WB_DW'(word_cnt);
      default:    rdata = '0;
    endcase
  end

  // Counter step, wrap detection and control-side events for this cycle.
  always_comb begin
    cnt_inc  = {1'b0, word_cnt} + 1'b1;
    cnt_step = enable & word_done;
    wrap     = cnt_step & (buf_size != '0) & (cnt_inc >= {1'b0, buf_size});
    en_rise  = wr & (off == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0] & ~enable;
    pend_clr = wr & (off == REG_STATUS) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
  end

  // Bus termination: exactly one of ack/err for one cycle; data only on reads.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_err_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= req & mapped;
      wb.wbs_err_o <= req & ~mapped;
      wb.wbs_dat_o <= rd ? rdata : '0;
    end
  end

  // Configuration registers written through byte lanes; unmapped writes do nothing.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      start_adr  <= '0;
      buf_size   <= WB_AW'(8);
      burst_size <= WB_AW'(4);
    end else if (wr) begin
      case (off)
        REG_CTRL: begin
          if (wb.wbs_sel_i[0]) begin
            enable <= wb.wbs_dat_i[0];
            irq_en <= wb.wbs_dat_i[1];
          end
        end
        REG_START: start_adr  <= WB_AW'(merge(WB_DW'(start_adr),  wb.wbs_dat_i, wb.wbs_sel_i));
        REG_BUF:   buf_size   <= WB_AW'(merge(WB_DW'(buf_size),   wb.wbs_dat_i, wb.wbs_sel_i));
        REG_BURST: burst_size <= WB_AW'(merge(WB_DW'(burst_size), wb.wbs_dat_i, wb.wbs_sel_i));
        default: ;
      endcase
    end
  end

  // Word counter with buffer wrap; a wrap sets irq_pend and beats a same-cycle clear.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      word_cnt <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (en_rise)       word_cnt <= '0;
      else if (wrap)     word_cnt <= '0;
      else if (cnt_step) word_cnt <= cnt_inc[WB_AW-1:0];

      if (wrap)          irq_pend <= 1'b1;
      else if (pend_clr) irq_pend <= 1'b0;
    end
  end

  // Interrupt output, registered one cycle behind the pending flag.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) irq <= 1'b0;
    else            irq <= irq_pend & irq_en;
  end

endmodule

// File: tb/tb_wb_stream_reader_cfg.sv
// Self-checking bench for wb_stream_reader_cfg: table of bus vectors plus
// hand-written sequences for counting, wrap, W1C collision and reset mid-ack.
// Expected terminations are queued at drive time and matched when ack/err appears.
module tb_wb_stream_reader_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        word_done;
  logic        busy;
  logic        enable;
  logic [31:0] start_adr;
  logic [31:0] buf_size;
  logic [31:0] burst_size;
  logic        irq;

  always #5 clk = ~clk;

  wb_stream_reader_cfg_if #(.WB_AW(32), .WB_DW(32)) wb ();

  wb_stream_reader_cfg #(.WB_AW(32), .WB_DW(32)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb         (wb.slave),
    .word_done  (word_done),
    .busy       (busy),
    .enable     (enable),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size),
    .irq        (irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    string       name;
    logic [33:0] exp;   // {ack, err, dat}
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[25];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One classic cycle; optionally pulses word_done on the same edge the request is taken.
  task automatic bus(input string name, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input logic exp_err, input logic [31:0] exp_dat, input logic wd);
    sb_t e;
    int  n;
    e.name = name;
    e.exp  = {~exp_err, exp_err, (we | exp_err) ? 32'h0 : exp_dat};
    sb.push_back(e);
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
    word_done    = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      word_done = 1'b0;
      n++;
    end while (!(wb.wbs_ack_o || wb.wbs_err_o) && n < 4);
    check({"latency ", name}, 64'(n), 64'd1);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk);
  endtask

  task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    bus(name, 1'b0, adr, 32'h0, 4'hF, 1'b0, exp, 1'b0);
  endtask

  task automatic wr(input string name, input logic [31:0] adr, input logic [31:0] dat);
    bus(name, 1'b1, adr, dat, 4'hF, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      @(negedge clk);
      word_done = 1'b1;
      @(negedge clk);
      word_done = 1'b0;
    end
  endtask

  // Scoreboard: every termination must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wb.wbs_ack_o || wb.wbs_err_o) begin
      if (sb.size() == 0) begin
        check("spurious termination", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, 64'({wb.wbs_ack_o, wb.wbs_err_o, wb.wbs_dat_o}), 64'(mon_e.exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    wb.wbs_sel_i = '0;
    wb.wbs_cti_i = 3'b000;
    wb.wbs_bte_i = 2'b00;
    word_done    = 1'b0;
    busy         = 1'b1;
    rst_n        = 1'b0;

    //           we    adr     dat            sel    err   exp_dat
    tbl[0]  = '{1'b0, 32'h00, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h04, 32'h0,         4'hF, 1'b0, 32'h1};
    tbl[2]  = '{1'b0, 32'h08, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0C, 32'h0,         4'hF, 1'b0, 32'h8};
    tbl[4]  = '{1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'h4};
    tbl[5]  = '{1'b0, 32'h14, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h08, 32'h1000_0000, 4'h3, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h08, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h08, 32'h1000_0000, 4'hC, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h08, 32'h0,         4'hF, 1'b0, 32'h1000_0000};
    tbl[10] = '{1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h08, 32'h0,         4'hF, 1'b0, 32'h1000_0000};
    tbl[12] = '{1'b0, 32'h1C, 32'h0,         4'hF, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 32'h14, 32'h55,        4'hF, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h14, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 32'h00, 32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h00, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[17] = '{1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'h00BB_00DD};
    tbl[19] = '{1'b1, 32'h04, 32'hFFFF_FFFD, 4'hF, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 32'h04, 32'h0,         4'hF, 1'b0, 32'h1};
    tbl[21] = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    tbl[22] = '{1'b0, 32'h00, 32'h0,         4'hF, 1'b0, 32'h3};
    tbl[23] = '{1'b1, 32'h00, 32'h0,         4'hF, 1'b0, 32'h0};
    tbl[24] = '{1'b0, 32'h00, 32'h0,         4'hF, 1'b0, 32'h0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ack/err/dat", 64'({wb.wbs_ack_o, wb.wbs_err_o, wb.wbs_dat_o}), 64'd0);
    check("rst rty", 64'(wb.wbs_rty_o), 64'd0);
    check("rst enable/irq", 64'({enable, irq}), 64'd0);
    check("rst start_adr", 64'(start_adr), 64'h0);
    check("rst buf_size", 64'(buf_size), 64'h8);
    check("rst burst_size", 64'(burst_size), 64'h4);
    rst_n = 1'b1;

    // Register map, byte lanes, read-only fields and unmapped offsets.
    for (int i = 0; i < 25; i++) begin
      bus($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
          tbl[i].exp_err, tbl[i].exp_dat, 1'b0);
    end
    @(negedge clk);
    check("port start_adr", 64'(start_adr), 64'h1000_0000);
    check("port burst_size", 64'(burst_size), 64'h00BB_00DD);

    // Counting with wrap at 3 and irq one cycle behind irq_pend.
    wr("buf=3", 32'h0C, 32'd3);
    wr("ctrl=3", 32'h00, 32'd3);
    pulse(1);
    rd("cnt after 1", 32'h14, 32'd1);
    pulse(1);
    rd("cnt after 2", 32'h14, 32'd2);
    @(negedge clk);
    word_done = 1'b1;
    @(negedge clk);
    word_done = 1'b0;
    check("irq before lag", 64'(irq), 64'd0);
    @(negedge clk);
    check("irq after lag", 64'(irq), 64'd1);
    rd("cnt after 3", 32'h14, 32'd0);
    rd("status pend", 32'h04, 32'd3);
    pulse(4);
    rd("cnt after 7", 32'h14, 32'd1);

    // W1C on the same edge as a wrapping word: set wins.
    pulse(1);
    bus("w1c+wrap", 1'b1, 32'h04, 32'h2, 4'hF, 1'b0, 32'h0, 1'b1);
    rd("status set wins", 32'h04, 32'd3);
    rd("cnt collision", 32'h14, 32'd0);
    @(negedge clk);
    check("irq held", 64'(irq), 64'd1);
    wr("w1c", 32'h04, 32'h2);
    @(negedge clk);
    check("irq dropped", 64'(irq), 64'd0);
    rd("status cleared", 32'h04, 32'd1);

    // Disabled counter ignores words; buf_size=0 counts without wrapping.
    wr("ctrl=2", 32'h00, 32'd2);
    @(negedge clk);
    check("enable off", 64'(enable), 64'd0);
    pulse(5);
    rd("cnt disabled", 32'h14, 32'd0);
    wr("buf=0", 32'h0C, 32'd0);
    wr("ctrl=1", 32'h00, 32'd1);
    pulse(10);
    rd("cnt no wrap", 32'h14, 32'd10);
    @(negedge clk);
    check("irq no wrap", 64'(irq), 64'd0);
    rd("status no wrap", 32'h04, 32'd1);
    wr("ctrl=0", 32'h00, 32'd0);
    wr("ctrl=1 again", 32'h00, 32'd1);
    rd("cnt cleared on enable", 32'h14, 32'd0);

    // Shrinking buf_size below the count wraps on the next word.
    wr("buf=5", 32'h0C, 32'd5);
    pulse(3);
    rd("cnt before shrink", 32'h14, 32'd3);
    wr("buf=2", 32'h0C, 32'd2);
    pulse(1);
    rd("cnt after shrink", 32'h14, 32'd0);
    rd("status after shrink", 32'h04, 32'd3);

    // Reset asserted during the ack cycle of a CTRL write.
    mon_e.name = "ctrl wr before rst";
    mon_e.exp  = {1'b1, 1'b0, 32'h0};
    sb.push_back(mon_e);
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = 32'h00;
    wb.wbs_dat_i = 32'h3;
    wb.wbs_sel_i = 4'hF;
    @(posedge clk);
    #1;
    check("ack pre-rst", 64'(wb.wbs_ack_o), 64'd1);
    rst_n        = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk);
    #1;
    check("mid rst ack/err", 64'({wb.wbs_ack_o, wb.wbs_err_o}), 64'd0);
    check("mid rst enable/irq", 64'({enable, irq}), 64'd0);
    check("mid rst start_adr", 64'(start_adr), 64'h0);
    check("mid rst buf/burst", 64'({buf_size, burst_size}), 64'h0000_0008_0000_0004);
    @(negedge clk);
    rst_n = 1'b1;
    rd("ctrl after rst", 32'h00, 32'd0);
    rd("cnt after rst", 32'h14, 32'd0);
    rd("status after rst", 32'h04, 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
